// File: rtl/calc_seq_ctrl.sv
// Keypad sequencer for the 1-digit calculator. Result is valid one cycle after S_EXEC; key_ready drops only in S_EXEC.
// Optional result chaining from S_DONE is built when CALC_CHAIN_EN is defined.

module calc_1digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [7:0] result,
  output logic       error
);
  always_comb begin
    result = '0;
    error  = 1'b0;
    case (op)
      2'b00: result = {4'b0, a} + {4'b0, b};
      2'b01: result = {4'b0, a} - {4'b0, b};
      2'b10: result = {4'b0, a} * {4'b0, b};
      default: begin
        if (b == 4'd0) error = 1'b1;
        else           result = {4'b0, a} / {4'b0, b};
      end
    endcase
  end
endmodule

module calc_seq_ctrl #(
  parameter int DIGIT_MAX    = 9,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [1:0] key_type,
  input  logic [3:0] key_data,
  output logic [3:0] a_disp,
  output logic [3:0] b_disp,
  output logic [1:0] op_disp,
  output logic [2:0] state_o,
  output logic [7:0] result,
  output logic       error,
  output logic       result_valid,
  output logic       done
);
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EQ   = 3'd3,
    S_EXEC = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int             CW       = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = (IDLE_TIMEOUT > 0) ? CW'(IDLE_TIMEOUT - 1) : '0;
  localparam logic [3:0]     DMAX     = 4'(DIGIT_MAX);

  state_t        state, state_n;
  logic [3:0]    a_n, b_n;
  logic [1:0]    op_n;
  logic [7:0]    res_n;
  logic          err_n, rv_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept, waiting, timeout, digit_ok, do_clear;
  logic [7:0]    alu_res;
  logic          alu_err;

  calc_1digit u_alu (
    .a      (a_disp),
    .b      (b_disp),
    .op     (op_disp),
    .result (alu_res),
    .error  (alu_err)
  );

  assign key_ready = (state != S_EXEC);
  assign accept    = key_valid & key_ready;
  assign waiting   = (state == S_OP) || (state == S_B) || (state == S_EQ);
  // The timeout fires on the edge at which the idle count would reach IDLE_TIMEOUT.
  assign timeout   = (IDLE_TIMEOUT > 0) && waiting && !accept && (cnt == CNT_LAST);
  assign digit_ok  = (key_data <= DMAX);
  assign do_clear  = (accept && (key_type == 2'b11)) || timeout;
  assign state_o   = state;
  assign done      = (state == S_DONE);

  always_comb begin
    state_n = state;
    a_n     = a_disp;
    b_n     = b_disp;
    op_n    = op_disp;
    res_n   = result;
    err_n   = error;
    rv_n    = 1'b0;
    if (state == S_EXEC) begin
      res_n   = alu_res;
      err_n   = alu_err;
      rv_n    = 1'b1;
      state_n = S_DONE;
    end else if (do_clear) begin
      state_n = S_A;
      a_n     = '0;
      b_n     = '0;
      op_n    = '0;
      res_n   = '0;
      err_n   = 1'b0;
    end else if (accept) begin
      case (key_type)
        2'b00: begin
          if (digit_ok) begin
            case (state)
              S_A, S_OP: begin
                a_n     = key_data;
                state_n = S_OP;
              end
              S_B, S_EQ: begin
                b_n     = key_data;
                state_n = S_EQ;
              end
              S_DONE: begin
                a_n     = key_data;
                b_n     = '0;
                op_n    = '0;
                res_n   = '0;
                err_n   = 1'b0;
                state_n = S_OP;
              end
              default: ;
            endcase
          end
        end
        2'b01: begin
          case (state)
            S_OP, S_B: begin
              op_n    = key_data[1:0];
              state_n = S_B;
            end
`ifdef CALC_CHAIN_EN
            S_DONE: begin
              // Only a result that fits a digit can seed the next operand A.
              if (!error && (result <= 8'd15)) begin
                a_n     = result[3:0];
                op_n    = key_data[1:0];
                b_n     = '0;
                err_n   = 1'b0;
                state_n = S_B;
              end else begin
                res_n = '0;
                err_n = 1'b1;
                rv_n  = 1'b1;
              end
            end
`endif
            default: ;
          endcase
        end
        2'b10: begin
          if (state == S_EQ) state_n = S_EXEC;
        end
        default: ;
      endcase
    end

    cnt_n = '0;
    if ((IDLE_TIMEOUT > 0) && waiting && !accept && (state_n == state))
      cnt_n = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_A;
      a_disp       <= '0;
      b_disp       <= '0;
      op_disp      <= '0;
      result       <= '0;
      error        <= 1'b0;
      result_valid <= 1'b0;
      cnt          <= '0;
    end else begin
      state        <= state_n;
      a_disp       <= a_n;
      b_disp       <= b_n;
      op_disp      <= op_n;
      result       <= res_n;
      error        <= err_n;
      result_valid <= rv_n;
      cnt          <= cnt_n;
    end
  end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed and random key streams against a cycle-stepped calculator model.
module tb_calc_seq_ctrl;
  localparam int TMO = 4;
  localparam logic [1:0] K_DIG = 2'b00, K_OP = 2'b01, K_EQ = 2'b10, K_CLR = 2'b11;

  logic       clk, rst, key_valid, key_ready;
  logic [1:0] key_type;
  logic [3:0] key_data;
  logic [3:0] a_disp, b_disp;
  logic [1:0] op_disp;
  logic [2:0] state_o;
  logic [7:0] result;
  logic       error, result_valid, done;

  int n_checks = 0;
  int n_fail   = 0;

  // model: stage numbers follow the displayed state numbering
  int m_stage, m_a, m_b, m_op, m_res, m_err, m_rv, m_idle;

  calc_seq_ctrl #(.DIGIT_MAX(9), .IDLE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_type(key_type), .key_data(key_data), .a_disp(a_disp), .b_disp(b_disp),
    .op_disp(op_disp), .state_o(state_o), .result(result), .error(error),
    .result_valid(result_valid), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_stage = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_rv = 0; m_idle = 0;
  endtask

  task automatic check_all();
    check("key_ready", {31'b0, key_ready}, (m_stage != 4) ? 1 : 0);
    check("state", {29'b0, state_o}, m_stage);
    check("a", {28'b0, a_disp}, m_a);
    check("b", {28'b0, b_disp}, m_b);
    check("op", {30'b0, op_disp}, m_op);
    check("result", {24'b0, result}, m_res);
    check("error", {31'b0, error}, m_err);
    check("result_valid", {31'b0, result_valid}, m_rv);
    check("done", {31'b0, done}, (m_stage == 5) ? 1 : 0);
  endtask

  task automatic model_key(input logic [1:0] t, input int d);
    case (t)
      K_CLR: model_clear();
      K_DIG: if (d <= 9) begin
        if (m_stage == 0 || m_stage == 1) begin m_a = d; m_stage = 1; end
        else if (m_stage == 2 || m_stage == 3) begin m_b = d; m_stage = 3; end
        else if (m_stage == 5) begin
          m_a = d; m_b = 0; m_op = 0; m_res = 0; m_err = 0; m_stage = 1;
        end
      end
      K_OP: begin
        if (m_stage == 1 || m_stage == 2) begin m_op = d % 4; m_stage = 2; end
`ifdef CALC_CHAIN_EN
        else if (m_stage == 5) begin
          if (m_err == 0 && m_res <= 15) begin
            m_a = m_res; m_op = d % 4; m_b = 0; m_stage = 2;
          end else begin
            m_res = 0; m_err = 1; m_rv = 1;
          end
        end
`endif
      end
      default: if (m_stage == 3) m_stage = 4;
    endcase
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  task automatic step(input logic v, input logic [1:0] t, input logic [3:0] d);
    int  prev;
    bit  acc;
    key_valid = v; key_type = t; key_data = d;
    prev = m_stage;
    acc  = v && (m_stage != 4);
    m_rv = 0;
    if (m_stage == 4) begin
      m_err = 0;
      case (m_op)
        0: m_res = m_a + m_b;
        1: m_res = (m_a - m_b) & 255;
        2: m_res = m_a * m_b;
        default: if (m_b == 0) begin m_res = 0; m_err = 1; end else m_res = m_a / m_b;
      endcase
      m_rv = 1;
      m_stage = 5;
    end else if (acc) begin
      model_key(t, int'(d));
    end else if (m_stage >= 1 && m_stage <= 3 && m_idle + 1 == TMO) begin
      model_clear();
    end
    if (!acc && m_stage == prev && m_stage >= 1 && m_stage <= 3) m_idle++;
    else m_idle = 0;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    check_all();
  endtask

  task automatic press(input logic [1:0] t, input logic [3:0] d);
    step(1'b1, t, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, K_DIG, 4'd0);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_type = K_DIG; key_data = 4'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    press(K_DIG, 4'd7); press(K_OP, 4'd0); press(K_DIG, 4'd5); press(K_EQ, 4'd0);
    check("exec_state", {29'b0, state_o}, 4);
    idle(1);
    check("add_result", {24'b0, result}, 12);
    check("add_valid", {31'b0, result_valid}, 1);
    idle(1);
    check("valid_pulse", {31'b0, result_valid}, 0);

    press(K_CLR, 4'd0);
    press(K_DIG, 4'd3); press(K_OP, 4'd1); press(K_DIG, 4'd5); press(K_EQ, 4'd0);
    idle(1);
    check("sub_wrap", {24'b0, result}, 32'hFE);

    press(K_CLR, 4'd0);
    press(K_DIG, 4'd9); press(K_OP, 4'd2); press(K_DIG, 4'd9); press(K_EQ, 4'd0);
    idle(1);
    check("mul", {24'b0, result}, 81);

    press(K_CLR, 4'd0);
    press(K_DIG, 4'd8); press(K_OP, 4'd3); press(K_DIG, 4'd0); press(K_EQ, 4'd0);
    idle(2);
    check("div0_err", {31'b0, error}, 1);
    check("div0_res", {24'b0, result}, 0);
    check("div0_done", {31'b0, done}, 1);
    press(K_DIG, 4'd4);
    check("restart_err", {31'b0, error}, 0);
    check("restart_a", {28'b0, a_disp}, 4);
    check("restart_state", {29'b0, state_o}, 1);

    press(K_DIG, 4'd2); press(K_OP, 4'd0); press(K_DIG, 4'd3); press(K_CLR, 4'd0);
    check("clr_state", {29'b0, state_o}, 0);
    check("clr_b", {28'b0, b_disp}, 0);
    press(K_DIG, 4'd12);
    check("drop_state", {29'b0, state_o}, 0);
    check("drop_a", {28'b0, a_disp}, 0);

    press(K_DIG, 4'd6); idle(3);
    check("tmo_wait", {29'b0, state_o}, 1);
    idle(1);
    check("tmo_fire", {29'b0, state_o}, 0);
    check("tmo_a", {28'b0, a_disp}, 0);
    press(K_DIG, 4'd6); idle(3); press(K_DIG, 4'd2); idle(3);
    check("tmo_restart", {29'b0, state_o}, 1);
    idle(1);

    press(K_DIG, 4'd1); press(K_OP, 4'd0); press(K_DIG, 4'd1); press(K_EQ, 4'd0);
    check("pre_rst_exec", {29'b0, state_o}, 4);
    #2 rst = 1'b1;
    #1;
    check("rst_state", {29'b0, state_o}, 0);
    check("rst_valid", {31'b0, result_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();

    press(K_DIG, 4'd4); press(K_OP, 4'd0); press(K_DIG, 4'd5); press(K_EQ, 4'd0);
    idle(2);
`ifdef CALC_CHAIN_EN
    press(K_OP, 4'd2);
    check("chain_state", {29'b0, state_o}, 2);
    check("chain_a", {28'b0, a_disp}, 9);
    press(K_DIG, 4'd2); press(K_EQ, 4'd0);
    idle(1);
    check("chain_result", {24'b0, result}, 18);
    idle(1);
    press(K_OP, 4'd0);
    check("chain_ovf_err", {31'b0, error}, 1);
    check("chain_ovf_valid", {31'b0, result_valid}, 1);
    check("chain_ovf_state", {29'b0, state_o}, 5);
`else
    press(K_OP, 4'd2);
    check("nochain_state", {29'b0, state_o}, 5);
    check("nochain_result", {24'b0, result}, 9);
`endif
    press(K_CLR, 4'd0);

    for (int i = 0; i < 600; i++) begin
      int r;
      logic [1:0] t;
      r = int'($urandom_range(0, 15));
      t = (r < 7) ? K_DIG : (r < 11) ? K_OP : (r < 15) ? K_EQ : K_CLR;
      step(($urandom_range(0, 2) != 0), t, 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
